// File: rtl/load_store_unit.sv
// load_store_unit
// Purpose: bridges a single-issue pipeline access request onto a word-wide data
// memory. Word accesses go straight through. Byte and halfword accesses use
// big-endian lane selection. Loads are sign- or zero-extended. Sub-word stores
// use a read-modify-write sequence.
//
// Configuration macro: LSU_SUBWORD_EN
//   defined   - byte/halfword loads and stores are supported.
//   undefined - only word accesses exist; sizes 00/01 are reported as errors.
//
// Ports:
//   clk, reset       - clock; asynchronous active-high reset
//   req_*            - request handshake (valid/ready), write flag, size,
//                      unsigned flag, byte address, right-justified store data
//   resp_*           - one-cycle completion pulse with load data and error flag
//   mem_*            - word-aligned data-memory port; read data returns
//                      combinationally, writes commit on the next clock edge
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        req_bad;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [29:0] waddr_q, waddr_d;
    // data_q holds the store word before WRITE (raw or merged).
    // After a load it holds the extended load result.
    logic [31:0] data_q, data_d;
    logic [31:0] load_value;

`ifdef LSU_SUBWORD_EN
    logic [1:0]  offset_q, offset_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] merge_value;
`else
    logic        unused_req_unsigned;
    assign unused_req_unsigned = req_unsigned;
    assign load_value          = mem_read_data;
`endif

    // Request legality, evaluated on the live request at acceptance.
    always_comb begin
        case (req_size)
`ifdef LSU_SUBWORD_EN
            SIZE_BYTE: req_bad = 1'b0;
            SIZE_HALF: req_bad = req_addr[0];
`endif
            SIZE_WORD: req_bad = (req_addr[1:0] != 2'b00);
            default:   req_bad = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_d = ST_RESP;
                    end else if (!req_write) begin
                        state_d = ST_LOAD;
`ifdef LSU_SUBWORD_EN
                    end else if (req_size != SIZE_WORD) begin
                        state_d = ST_RMW_READ;
`endif
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_LOAD:     state_d = ST_RESP;
`ifdef LSU_SUBWORD_EN
            ST_RMW_READ: state_d = ST_WRITE;
`endif
            ST_WRITE:    state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. Everything is decoded from state.
    // This lets an asynchronous reset silence the memory strobes immediately.
    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        resp_valid     = (state_q == ST_RESP);
        resp_error     = (state_q == ST_RESP) && err_q;
        resp_rdata     = ((state_q == ST_RESP) && !err_q && !write_q) ? data_q : 32'h0;
        mem_read       = (state_q == ST_LOAD) || (state_q == ST_RMW_READ);
        mem_write      = (state_q == ST_WRITE);
        mem_address    = (mem_read || mem_write) ? {waddr_q, 2'b00} : 32'h0;
        mem_write_data = mem_write ? data_q : 32'h0;
    end

    // Request capture and data path
    always_comb begin
        write_d = write_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        data_d  = data_q;
`ifdef LSU_SUBWORD_EN
        offset_d   = offset_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    err_d   = req_bad;
                    waddr_d = req_addr[31:2];
                    data_d  = req_wdata;
`ifdef LSU_SUBWORD_EN
                    offset_d   = req_addr[1:0];
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
`endif
                end
            end
            ST_LOAD:     data_d = load_value;
`ifdef LSU_SUBWORD_EN
            ST_RMW_READ: data_d = merge_value;
`endif
            default: ;
        endcase
    end

`ifdef LSU_SUBWORD_EN
    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        case (offset_q)
            2'd0:    lane_byte = mem_read_data[31:24];
            2'd1:    lane_byte = mem_read_data[23:16];
            2'd2:    lane_byte = mem_read_data[15:8];
            default: lane_byte = mem_read_data[7:0];
        endcase
        lane_half = offset_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
        case (size_q)
            SIZE_BYTE: load_value = {{24{!unsigned_q && lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_value = {{16{!unsigned_q && lane_half[15]}}, lane_half};
            default:   load_value = mem_read_data;
        endcase
    end

    // Store merge: data_q still holds the right-justified store data here.
    always_comb begin
        merge_value = mem_read_data;
        case (size_q)
            SIZE_BYTE: begin
                case (offset_q)
                    2'd0:    merge_value[31:24] = data_q[7:0];
                    2'd1:    merge_value[23:16] = data_q[7:0];
                    2'd2:    merge_value[15:8]  = data_q[7:0];
                    default: merge_value[7:0]   = data_q[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (offset_q[1]) begin
                    merge_value[15:0] = data_q[15:0];
                end else begin
                    merge_value[31:16] = data_q[15:0];
                end
            end
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= 30'h0;
            data_q  <= 32'h0;
`ifdef LSU_SUBWORD_EN
            offset_q   <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
`endif
        end else begin
            write_q <= write_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
`ifdef LSU_SUBWORD_EN
            offset_q   <= offset_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit.
// It uses a small behavioural word memory.
// Sub-word scenarios are selected with LSU_SUBWORD_EN, matching the DUT build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    // Behavioural memory plus monotonic event counters
    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'h0;
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, wr_at = 0, resp_cnt = 0, acc_cnt = 0;

    assign mem_read_data = mem[mem_address[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt <= wr_cnt + 1;
            wr_at  <= cyc;
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_idx  = a[7:2];
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its response.
    // Latency is counted in cycles after the acceptance edge (-1 = none).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nrd, output int nwr, output int wr_off);
        int r0, w0, acc;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        r0 = rd_cnt; w0 = wr_cnt;
        tick();
        acc = cyc - 1;
        req_valid = 1'b0;
        lat = -1; rd = 32'h0; er = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_error;
                break;
            end
            tick();
        end
        nrd = rd_cnt - r0;
        nwr = wr_cnt - w0;
        wr_off = wr_at - acc;
        $display("req w=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d reads=%0d writes=%0d",
                 w, sz, u, a, wd, lat, rd, er, nrd, nwr);
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_error, mem_read, mem_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got %b exp 0000", {resp_valid, resp_error, mem_read, mem_write});
        end
        checks++;
        if ({resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
            errors++; $display("FAIL reset_buses got %h/%h/%h exp 0", resp_rdata, mem_address, mem_write_data);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_word();
        int lat, nrd, nwr, wo; logic [31:0] rd; logic er;
        preload(32'h40, 32'h8081_7F00);
        preload(32'h20, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 2 || er !== 1'b0) begin
            errors++; $display("FAIL lw_latency got lat=%0d err=%b exp lat=2 err=0", lat, er);
        end
        checks++;
        if (rd !== 32'h8081_7F00 || nrd !== 1 || nwr !== 0) begin
            errors++; $display("FAIL lw_data got %h r=%0d w=%0d exp 80817f00 r=1 w=0", rd, nrd, nwr);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sw_resp got lat=%0d err=%b rdata=%h exp 2/0/0", lat, er, rd);
        end
        checks++;
        if (mem[8] !== 32'hDEAD_BEEF || nwr !== 1 || nrd !== 0 || wo !== 1) begin
            errors++; $display("FAIL sw_mem got %h w=%0d r=%0d off=%0d exp deadbeef 1/0/1", mem[8], nwr, nrd, wo);
        end
    endtask

    task automatic test_misaligned();
        int lat, nrd, nwr, wo; logic [31:0] rd; logic er;
        do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0) begin
            errors++; $display("FAIL lw_misaligned got lat=%0d err=%b rd=%h r=%0d w=%0d exp 1/1/0/0/0", lat, er, rd, nrd, nwr);
        end
        do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h1234_5678, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 1 || er !== 1'b1 || nwr !== 0 || mem[16] !== 32'h8081_7F00) begin
            errors++; $display("FAIL size11_store got lat=%0d err=%b w=%0d mem=%h exp 1/1/0/80817f00", lat, er, nwr, mem[16]);
        end
    endtask

    task automatic test_reset_during_write();
        int w0, r0;
        preload(32'h10, 32'h55AA_55AA);
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_write !== 1'b1 || mem_write_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rst_write_phase got we=%b data=%h exp 1/deadbeef", mem_write, mem_write_data);
        end
        w0 = wr_cnt; r0 = resp_cnt;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async got we=%b ready=%b rv=%b exp 0/1/0", mem_write, req_ready, resp_valid);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) tick();
        checks++;
        if (mem[4] !== 32'h55AA_55AA || wr_cnt !== w0 || resp_cnt !== r0) begin
            errors++; $display("FAIL rst_discard got mem=%h dw=%0d dr=%0d exp 55aa55aa/0/0", mem[4], wr_cnt - w0, resp_cnt - r0);
        end
        $display("req reset during word store addr=00000010 -> mem=%h", mem[4]);
    endtask

    task automatic test_back_to_back();
        int a0;
        preload(32'h40, 32'h8081_7F00);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        req_valid = 1'b1;
        a0 = acc_cnt;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({req_ready, mem_read, resp_valid} !== {(k % 3 == 0), (k % 3 == 1), (k % 3 == 2)}) begin
                errors++; $display("FAIL b2b_phase k=%0d got rdy/rd/rv=%b%b%b exp %b%b%b", k, req_ready, mem_read, resp_valid,
                                   (k % 3 == 0), (k % 3 == 1), (k % 3 == 2));
            end
            if (k % 3 == 2) begin
                checks++;
                if (resp_rdata !== 32'h8081_7F00) begin
                    errors++; $display("FAIL b2b_data k=%0d got %h exp 80817f00", k, resp_rdata);
                end
                $display("req b2b load word addr=00000040 -> rdata=%h", resp_rdata);
            end
        end
        req_valid = 1'b0;
        tick();
        checks++;
        if (acc_cnt - a0 !== 4) begin
            errors++; $display("FAIL b2b_accepts got %0d exp 4", acc_cnt - a0);
        end
    endtask

`ifdef LSU_SUBWORD_EN
    task automatic test_subword();
        int lat, nrd, nwr, wo; logic [31:0] rd; logic er;
        preload(32'h40, 32'h8081_7F00);
        do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hFFFF_FF81) begin
            errors++; $display("FAIL lb_signed got lat=%0d err=%b rd=%h exp 2/0/ffffff81", lat, er, rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0000_7F00) begin
            errors++; $display("FAIL lhu got lat=%0d err=%b rd=%h exp 2/0/00007f00", lat, er, rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu got %h exp 00000080", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (rd !== 32'hFFFF_8081) begin
            errors++; $display("FAIL lh_signed got %h exp ffff8081", rd);
        end
        preload(32'h40, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h43, 32'h0000_00AB, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 3 || er !== 1'b0 || nwr !== 1 || nrd !== 1 || wo !== 2) begin
            errors++; $display("FAIL sb_timing got lat=%0d err=%b w=%0d r=%0d off=%0d exp 3/0/1/1/2", lat, er, nwr, nrd, wo);
        end
        checks++;
        if (mem[16] !== 32'h1122_33AB) begin
            errors++; $display("FAIL sb_merge got %h exp 112233ab", mem[16]);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h40, 32'h1234_CAFE, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 3 || mem[16] !== 32'hCAFE_33AB) begin
            errors++; $display("FAIL sh_merge got lat=%0d mem=%h exp 3/cafe33ab", lat, mem[16]);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 1 || er !== 1'b1 || nrd !== 0) begin
            errors++; $display("FAIL lh_misaligned got lat=%0d err=%b r=%0d exp 1/1/0", lat, er, nrd);
        end
    endtask
`else
    task automatic test_subword_disabled();
        int lat, nrd, nwr, wo; logic [31:0] rd; logic er;
        do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nrd !== 0) begin
            errors++; $display("FAIL lb_disabled got lat=%0d err=%b rd=%h r=%0d exp 1/1/0/0", lat, er, rd, nrd);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h40, 32'h0000_CAFE, lat, rd, er, nrd, nwr, wo);
        checks++;
        if (lat !== 1 || er !== 1'b1 || nwr !== 0 || mem[16] !== 32'h8081_7F00) begin
            errors++; $display("FAIL sh_disabled got lat=%0d err=%b w=%0d mem=%h exp 1/1/0/80817f00", lat, er, nwr, mem[16]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_misaligned();
        test_reset_during_write();
        test_back_to_back();
`ifdef LSU_SUBWORD_EN
        test_subword();
`else
        test_subword_disabled();
`endif
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL strobe_overlap got %0d exp 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
